line_feeder: RTL



---
 rtl/line_feeder.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/line_feeder.sv
// Read-side line feeder: fills a ping-pong pair of line buffers from the upstream
// stream, announces each full line and serves the consumer's reads one word per strobe.
module line_feeder #(
    parameter int WIDTH  = 1600,
    parameter int HEIGHT = 1200,
    parameter int ADDR_W = 11
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        FRAME_START,
    input  logic        SRC_VALID,
    output logic        SRC_READY,
    input  logic [31:0] SRC_DATA,
    output logic        READ_LINE_DONE,
    output logic [11:0] READ_POSY,
    input  logic        IN_DE,
    output logic [31:0] IN_DATA,
    input  logic        WRITE_LINE_DONE,
    output logic        FRAME_DONE,
    output logic        OVERRUN
);

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2,
        BANK_READING = 2'd3
    } bank_t;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_SERVE   = 2'd2,
        S_WAIT_WB = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_PTR   = ADDR_W'(WIDTH - 1);
    localparam logic [11:0]       HEIGHT_ROW = 12'(HEIGHT);
    localparam logic [11:0]       LAST_ROW   = 12'(HEIGHT - 1);

    state_t              state_reg;
    state_t              state_next;
    bank_t               bank_state_reg [2];
    logic [11:0]         tag_reg [2];
    logic                frame_active_reg;
    logic                wsel_reg;
    logic                rsel_reg;
    logic [ADDR_W-1:0]   wr_ptr_reg;
    logic [ADDR_W-1:0]   rd_ptr_reg;
    logic [11:0]         fill_line_reg;
    logic                credit_reg;
    logic                wld_prev_reg;
    logic                read_line_done_reg;
    logic [11:0]         read_posy_reg;
    logic [31:0]         in_data_reg;
    logic                frame_done_reg;
    logic                overrun_reg;

    // Both banks share one array; the bank select is the top address bit.
    logic [31:0]         mem [0:(2**(ADDR_W+1))-1];

    logic bank_writable;
    logic fill_fire;
    logic fill_last;
    logic read_fire;
    logic read_last;
    logic issue_go;
    logic wld_rise;
    logic last_row_done;

    always_comb begin
        bank_writable = (bank_state_reg[wsel_reg] == BANK_EMPTY) ||
                        (bank_state_reg[wsel_reg] == BANK_FILLING);
        SRC_READY     = frame_active_reg && bank_writable && (fill_line_reg < HEIGHT_ROW);
        fill_fire     = SRC_VALID && SRC_READY;
        fill_last     = fill_fire && (wr_ptr_reg == LAST_PTR);
        read_fire     = IN_DE && (state_reg == S_SERVE);
        read_last     = read_fire && (rd_ptr_reg == LAST_PTR);
        issue_go      = (state_reg == S_IDLE) && (bank_state_reg[rsel_reg] == BANK_FULL) && credit_reg;
        wld_rise      = WRITE_LINE_DONE && !wld_prev_reg;
        last_row_done = (state_reg == S_WAIT_WB) && wld_rise && (read_posy_reg == LAST_ROW);
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:    if (issue_go) state_next = S_ISSUE;
            S_ISSUE:   state_next = S_SERVE;
            S_SERVE:   if (read_last) state_next = S_WAIT_WB;
            S_WAIT_WB: if (wld_rise) state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST || FRAME_START) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Fill and free never hit the same bank in one cycle, so each bank updates on its own.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            always_ff @(posedge CLK) begin
                if (!RST || FRAME_START) begin
                    bank_state_reg[gi] <= BANK_EMPTY;
                    tag_reg[gi]        <= 12'd0;
                end else if (fill_fire && (wsel_reg == 1'(gi))) begin
                    bank_state_reg[gi] <= fill_last ? BANK_FULL : BANK_FILLING;
                    if (fill_last) begin
                        tag_reg[gi] <= fill_line_reg;
                    end
                end else if ((state_reg == S_ISSUE) && (rsel_reg == 1'(gi))) begin
                    bank_state_reg[gi] <= BANK_READING;
                end else if (read_last && (rsel_reg == 1'(gi))) begin
                    bank_state_reg[gi] <= BANK_EMPTY;
                end
            end
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (fill_fire) begin
            mem[{wsel_reg, wr_ptr_reg}] <= SRC_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            in_data_reg <= 32'd0;
        end else if (read_fire && !FRAME_START) begin
            in_data_reg <= mem[{rsel_reg, rd_ptr_reg}];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            frame_active_reg   <= 1'b0;
            wsel_reg           <= 1'b0;
            rsel_reg           <= 1'b0;
            wr_ptr_reg         <= '0;
            rd_ptr_reg         <= '0;
            fill_line_reg      <= 12'd0;
            credit_reg         <= 1'b1;
            wld_prev_reg       <= 1'b0;
            read_line_done_reg <= 1'b0;
            read_posy_reg      <= 12'd0;
            frame_done_reg     <= 1'b0;
            overrun_reg        <= 1'b0;
        end else if (FRAME_START) begin
            // Restart abandons any line in flight; the error flag survives.
            frame_active_reg   <= 1'b1;
            wsel_reg           <= 1'b0;
            rsel_reg           <= 1'b0;
            wr_ptr_reg         <= '0;
            rd_ptr_reg         <= '0;
            fill_line_reg      <= 12'd0;
            credit_reg         <= 1'b1;
            wld_prev_reg       <= WRITE_LINE_DONE;
            read_line_done_reg <= 1'b0;
            frame_done_reg     <= 1'b0;
        end else begin
            wld_prev_reg       <= WRITE_LINE_DONE;
            read_line_done_reg <= issue_go;
            frame_done_reg     <= last_row_done;
            if (issue_go) begin
                read_posy_reg <= tag_reg[rsel_reg];
            end
            if (state_reg == S_ISSUE) begin
                credit_reg <= 1'b0;
                rd_ptr_reg <= '0;
            end
            if (fill_fire) begin
                if (fill_last) begin
                    wr_ptr_reg    <= '0;
                    fill_line_reg <= fill_line_reg + 12'd1;
                    wsel_reg      <= !wsel_reg;
                end else begin
                    wr_ptr_reg <= wr_ptr_reg + 1'b1;
                end
            end
            if (read_fire) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
                if (read_last) begin
                    rsel_reg <= !rsel_reg;
                end
            end
            if ((state_reg == S_WAIT_WB) && wld_rise) begin
                credit_reg <= 1'b1;
                if (read_posy_reg == LAST_ROW) begin
                    frame_active_reg <= 1'b0;
                end
            end
            if (IN_DE && (state_reg != S_SERVE)) begin
                overrun_reg <= 1'b1;
            end
        end
    end

    assign READ_LINE_DONE = read_line_done_reg;
    assign READ_POSY      = read_posy_reg;
    assign IN_DATA        = in_data_reg;
    assign FRAME_DONE     = frame_done_reg;
    assign OVERRUN        = overrun_reg;

endmodule
